// File: rtl/dual_entry_calc.sv
// Two-operand entry calculator: captures A and B on enter presses in any order, then runs
// add/sub in one cycle or a bit-serial multiply/restoring divide in W cycles.
module dual_entry_calc #(
  parameter int unsigned W  = 3,
  parameter int unsigned RW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  num1,
  input  logic [W-1:0]  num2,
  input  logic          enter1,
  input  logic          enter2,
  input  logic [1:0]    op,
  output logic [RW-1:0] res,
  output logic          res_valid,
  output logic          busy,
  output logic          err,
  output logic          neg
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  if (RW < 2 * W) begin : g_bad_rw
    $error("dual_entry_calc: RW must be at least 2*W");
  end
  if (W < 2) begin : g_bad_w
    $error("dual_entry_calc: W must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StCollect, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic            enter1_q, enter2_q;
  logic            press1, press2;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            have_a_q, have_a_d, have_b_q, have_b_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  prod_q, prod_d, mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [W-1:0]    rem_q, rem_d, quo_q, quo_d;
  logic [RW-1:0]   res_q, res_d;
  logic            valid_q, valid_d, err_q, err_d, neg_q, neg_d;

  // Datapath temporaries
  logic [W:0]      sum, diff, div_shift, div_trial;
  logic [2*W-1:0]  prod_next;

  assign press1 = enter1 & ~enter1_q;
  assign press2 = enter2 & ~enter2_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    have_a_d  = have_a_q;
    have_b_d  = have_b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    res_d     = res_q;
    valid_d   = valid_q;
    err_d     = err_q;
    neg_d     = neg_q;
    sum       = '0;
    diff      = '0;
    div_shift = '0;
    div_trial = '0;
    prod_next = '0;

    unique case (state_q)
      StIdle, StCollect, StDone: begin
        if (press1) begin
          a_d      = num1;
          have_a_d = 1'b1;
        end
        if (press2) begin
          b_d      = num2;
          have_b_d = 1'b1;
        end
        if (press1 || press2) begin
          valid_d = 1'b0;
          if (have_a_d && have_b_d) begin
            state_d  = StBusy;
            op_d     = op;
            have_a_d = 1'b0;
            have_b_d = 1'b0;
            cnt_d    = CW'(W - 1);
            prod_d   = '0;
            mcand_d  = {{W{1'b0}}, a_d};
            mplier_d = b_d;
            rem_d    = '0;
            quo_d    = a_d;
          end else begin
            state_d = StCollect;
          end
        end
      end

      StBusy: begin
        cnt_d = cnt_q - CW'(1);

        // One shift-add multiply step, LSB of multiplier first
        prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
        prod_d    = prod_next;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;

        // One restoring divide step; trial sign bit says whether B fits
        div_shift = {rem_q, quo_q[W-1]};
        div_trial = div_shift - {1'b0, b_q};
        if (!div_trial[W]) begin
          rem_d = div_trial[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = div_shift[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end

        if (!op_q[1] || cnt_q == '0) begin
          state_d = StDone;
          valid_d = 1'b1;
          res_d   = '0;
          err_d   = 1'b0;
          neg_d   = 1'b0;
          unique case (op_q)
            2'b00: begin
              sum        = {1'b0, a_q} + {1'b0, b_q};
              res_d[W:0] = sum;
            end
            2'b01: begin
              diff       = {1'b0, a_q} - {1'b0, b_q};
              res_d      = {RW{diff[W]}};
              res_d[W:0] = diff;
              neg_d      = (a_q < b_q);
            end
            2'b10: begin
              res_d[2*W-1:0] = prod_next;
            end
            default: begin
              if (b_q == '0) begin
                res_d = '1;
                err_d = 1'b1;
              end else begin
                res_d[W-1:0]   = quo_d;
                res_d[2*W-1:W] = rem_d;
              end
            end
          endcase
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      enter1_q <= 1'b0;
      enter2_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      have_a_q <= 1'b0;
      have_b_q <= 1'b0;
      op_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      enter1_q <= enter1;
      enter2_q <= enter2;
      a_q      <= a_d;
      b_q      <= b_d;
      have_a_q <= have_a_d;
      have_b_q <= have_b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      neg_q    <= neg_d;
    end
  end

  assign res       = res_q;
  assign res_valid = valid_q;
  assign busy      = (state_q == StBusy);
  assign err       = err_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_dual_entry_calc.sv
// Bench for dual_entry_calc: directed scenarios with literal expectations plus random stimulus,
// all checked every cycle against a cycle-level behavioural model.
module tb_dual_entry_calc;

  localparam int unsigned W  = 3;
  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  num1 = '0, num2 = '0;
  logic          enter1 = 1'b0, enter2 = 1'b0;
  logic [1:0]    op = '0;
  logic [RW-1:0] res;
  logic          res_valid, busy, err, neg;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  dual_entry_calc #(.W(W), .RW(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .num1     (num1),
    .num2     (num2),
    .enter1   (enter1),
    .enter2   (enter2),
    .op       (op),
    .res      (res),
    .res_valid(res_valid),
    .busy     (busy),
    .err      (err),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  // Behavioural model: operands, pending flags, remaining busy cycles, result
  int          m_a = 0, m_b = 0, m_op = 0, m_left = 0;
  bit          m_ha = 0, m_hb = 0, m_e1 = 0, m_e2 = 0;
  logic [7:0]  m_res = '0;
  logic        m_valid = 0, m_err = 0, m_neg = 0;

  function automatic void calc(input int a, input int b, input int o,
                               output logic [7:0] r, output logic e, output logic n);
    e = 1'b0;
    n = 1'b0;
    case (o)
      0: r = 8'(a + b);
      1: begin
        r = 8'(a - b);
        n = (a < b);
      end
      2: r = 8'(a * b);
      default: begin
        if (b == 0) begin
          r = 8'hFF;
          e = 1'b1;
        end else begin
          r = 8'(((a % b) << W) | (a / b));
        end
      end
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ha = 0; m_hb = 0; m_e1 = 0; m_e2 = 0; m_left = 0;
      m_a = 0; m_b = 0; m_op = 0;
      m_res = '0; m_valid = 0; m_err = 0; m_neg = 0;
    end else begin
      bit p1, p2;
      p1 = enter1 && !m_e1;
      p2 = enter2 && !m_e2;
      m_e1 = enter1;
      m_e2 = enter2;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          calc(m_a, m_b, m_op, m_res, m_err, m_neg);
          m_valid = 1;
        end
      end else begin
        if (p1) begin m_a = int'(num1); m_ha = 1; end
        if (p2) begin m_b = int'(num2); m_hb = 1; end
        if (p1 || p2) begin
          m_valid = 0;
          if (m_ha && m_hb) begin
            m_ha = 0;
            m_hb = 0;
            m_op = int'(op);
            m_left = op[1] ? W : 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      checks++;
      if (res !== m_res || res_valid !== m_valid || busy !== (m_left > 0) ||
          err !== m_err || neg !== m_neg) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got res=%h valid=%b busy=%b err=%b neg=%b, want res=%h valid=%b busy=%b err=%b neg=%b",
                 $time, res, res_valid, busy, err, neg, m_res, m_valid, m_left > 0, m_err, m_neg);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Ends on the negedge just after the capture edge (edge 0)
  task automatic enter_pair(input int a, input int b, input int o, input bit same);
    @(negedge clk);
    op = 2'(o);
    if (same) begin
      num1 = W'(a); num2 = W'(b); enter1 = 1; enter2 = 1;
      @(negedge clk);
      enter1 = 0; enter2 = 0;
    end else begin
      num1 = W'(a); enter1 = 1;
      @(negedge clk);
      enter1 = 0;
      @(negedge clk);
      num2 = W'(b); enter2 = 1;
      @(negedge clk);
      enter2 = 0;
    end
  endtask

  task automatic wait_valid(input int start, output int edges);
    edges = start;
    while (res_valid !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  int lat;

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    run_cmp = 1;
    @(negedge clk);
    check("reset_res", 32'(res), 0);
    check("reset_flags", {res_valid, busy, err, neg}, 0);

    // T1: 1*1 via separate presses
    enter_pair(1, 1, 2, 0);
    check("t1_busy", 32'(busy), 1);
    wait_valid(0, lat);
    check("t1_lat", lat, 3);
    check("t1_res", 32'(res), 32'h01);

    // T2: 7*7 with simultaneous presses
    enter_pair(7, 7, 2, 1);
    check("t2_valid_cleared", 32'(res_valid), 0);
    wait_valid(0, lat);
    check("t2_lat", lat, 3);
    check("t2_res", 32'(res), 32'h31);
    check("t2_err", 32'(err), 0);

    // T3: subtraction both signs
    enter_pair(2, 5, 1, 0);
    wait_valid(0, lat);
    check("t3_lat", lat, 1);
    check("t3_res_neg", 32'(res), 32'hFD);
    check("t3_neg", 32'(neg), 1);
    enter_pair(5, 2, 1, 0);
    wait_valid(0, lat);
    check("t3_res_pos", 32'(res), 32'h03);
    check("t3_neg_clr", 32'(neg), 0);

    // T4: divide and divide by zero
    enter_pair(7, 2, 3, 0);
    wait_valid(0, lat);
    check("t4_res", 32'(res), 32'h0B);
    enter_pair(5, 0, 3, 0);
    wait_valid(0, lat);
    check("t4_lat_div0", lat, 3);
    check("t4_res_div0", 32'(res), 32'hFF);
    check("t4_err", 32'(err), 1);

    // T5: held enter1 captures only the first value; enter2 during BUSY is dropped
    @(negedge clk);
    op = 2'b10; num1 = 1; enter1 = 1;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      num1 = W'(i);
    end
    @(negedge clk);
    enter1 = 0;
    @(negedge clk);
    num2 = 3; enter2 = 1;
    @(negedge clk);
    enter2 = 0;
    @(negedge clk);
    num2 = 6; enter2 = 1;
    @(negedge clk);
    enter2 = 0;
    wait_valid(2, lat);
    check("t5_lat", lat, 3);
    check("t5_res", 32'(res), 32'h03);
    @(negedge clk);
    num1 = 4; enter1 = 1;
    @(negedge clk);
    enter1 = 0;
    repeat (3) @(negedge clk);
    check("t5_no_start", {busy, res_valid}, 0);
    num2 = 5; enter2 = 1;
    @(negedge clk);
    enter2 = 0;
    wait_valid(0, lat);
    check("t5_res2", 32'(res), 32'h14);

    // T6: asynchronous reset in the middle of a multiply
    enter_pair(3, 3, 2, 1);
    @(negedge clk);
    check("t6_busy", 32'(busy), 1);
    #2 reset = 1;
    #1;
    check("t6_res", 32'(res), 0);
    check("t6_flags", {res_valid, busy, err, neg}, 0);
    #1 reset = 0;
    enter_pair(6, 5, 2, 0);
    wait_valid(0, lat);
    check("t6_lat", lat, 3);
    check("t6_res_fresh", 32'(res), 32'h1E);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (reset) reset = 0;
      else if ($urandom_range(0, 149) == 0) reset = 1;
      enter1 = ($urandom_range(0, 3) == 0);
      enter2 = ($urandom_range(0, 3) == 0);
      num1   = W'($urandom);
      num2   = W'($urandom);
      op     = 2'($urandom);
    end
    @(negedge clk);
    reset = 0; enter1 = 0; enter2 = 0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
